// File: rtl/conv8_row_feeder_pkg.sv
// Shared types and geometry for the stride-2 / pad-1 conv row feeder.
package conv8_row_feeder_pkg;

  localparam int conv8_width = 8;
  localparam int ROW_LEN     = 8;
  localparam int K           = 3;
  localparam int N_OUT       = 4;

  typedef logic [2*conv8_width-1:0] psum_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/conv8_row_feeder_if.sv
// Beat/psum link between the row feeder (master) and the row PE array (slave).
interface conv8_row_feeder_if
  import conv8_row_feeder_pkg::*;
#(
  parameter int WIDTH = conv8_width
) ();

  logic               o_en;
  logic [WIDTH-1:0]   o_f;
  logic [WIDTH-1:0]   o_r;
  logic [2*WIDTH-1:0] i_psum;

  modport master (output o_en, output o_f, output o_r, input i_psum);
  modport slave  (input o_en, input o_f, input o_r, output i_psum);

endinterface

// File: rtl/conv8_psum_collector.sv
// Captures the serial psums into the packed result; ReLU clamp when CONV8_FEEDER_RELU_EN is defined.
module conv8_psum_collector
  import conv8_row_feeder_pkg::*;
#(
  parameter int WIDTH = conv8_width
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [2*WIDTH-1:0]       psum,
  output logic                     cap_last,
  output logic [N_OUT*2*WIDTH-1:0] res
);

  localparam int IDX_W = $clog2(N_OUT);

  logic [IDX_W-1:0]                idx_r;
  logic [N_OUT-1:0][2*WIDTH-1:0]   res_r;

  function automatic logic [2*WIDTH-1:0] relu_f(input logic [2*WIDTH-1:0] v);
`ifdef CONV8_FEEDER_RELU_EN
    relu_f = v[2*WIDTH-1] ? {(2*WIDTH){1'b0}} : v;
`else
    relu_f = v;
`endif
  endfunction

  assign cap_last = cap_en && (idx_r == IDX_W'(N_OUT-1));
  assign res      = res_r;

  // Capture index and packed result register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
      res_r <= '0;
    end else if (cap_en) begin
      res_r[idx_r] <= relu_f(psum);
      idx_r        <= cap_last ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
      res_r <= res_r;
    end
  end

endmodule

// File: rtl/conv8_row_feeder.sv
// Row/filter buffer and beat sequencer for the row PE array; optional ReLU via CONV8_FEEDER_RELU_EN.
module conv8_row_feeder
  import conv8_row_feeder_pkg::*;
#(
  parameter int WIDTH    = conv8_width,
  parameter int PSUM_LAT = 8,
  parameter int GAP      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [2:0]               wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  output logic                     busy,
  conv8_row_feeder_if.master       pe,
  output logic [N_OUT*2*WIDTH-1:0] o_res,
  output logic                     done
);

  localparam int CNT_W   = $clog2(((PSUM_LAT > ROW_LEN) ? PSUM_LAT : ROW_LEN) + 2);
  localparam int GAP_W   = $clog2(GAP + 1);
  localparam int ROW_AW  = $clog2(ROW_LEN);
  localparam int FILT_AW = $clog2(K);

  feeder_state_e     state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [GAP_W-1:0]  gap_r;
  logic [WIDTH-1:0]  row_r  [ROW_LEN];
  logic [WIDTH-1:0]  filt_r [K];
  logic              row_loaded_r, filt_loaded_r;
  logic              busy_r, done_r, o_en_r;
  logic [WIDTH-1:0]  o_f_r, o_r_r;
  logic [ROW_AW-1:0] nxt_beat_s;
  logic              start_ok_s, lat_hit_s, cap_en_s, cap_last_s, wr_ok_s;

  assign start_ok_s = start && row_loaded_r && filt_loaded_r && (gap_r == {GAP_W{1'b0}});
  assign lat_hit_s  = (int'(cnt_r) + 32'sd1 >= PSUM_LAT);
  assign cap_en_s   = (state_r == CAPT);
  assign wr_ok_s    = wr_en && (state_r == IDLE);
  // Beat 0 is launched on the accepting edge, so the next beat is 0 unless already sending
  assign nxt_beat_s = (state_r == SEND) ? cnt_r[ROW_AW-1:0] + ROW_AW'(1) : {ROW_AW{1'b0}};

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: state_s = start_ok_s ? SEND : IDLE;
      SEND: begin
        if (cnt_r == CNT_W'(ROW_LEN-1)) begin
          state_s = lat_hit_s ? CAPT : WAIT;
        end else begin
          state_s = SEND;
        end
      end
      WAIT:    state_s = lat_hit_s ? CAPT : WAIT;
      CAPT:    state_s = cap_last_s ? DONE : CAPT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, cycle counter and registered beat/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      o_en_r  <= 1'b0;
      o_f_r   <= {WIDTH{1'b0}};
      o_r_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (state_r == IDLE) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == SEND) || (state_r == WAIT)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_s == SEND) begin
        o_en_r <= 1'b1;
        o_r_r  <= row_r[nxt_beat_s];
        o_f_r  <= (int'(nxt_beat_s) < K) ? filt_r[nxt_beat_s[FILT_AW-1:0]] : {WIDTH{1'b0}};
      end else begin
        o_en_r <= 1'b0;
        o_f_r  <= {WIDTH{1'b0}};
        o_r_r  <= {WIDTH{1'b0}};
      end
    end
  end

  // Buffer loads, loaded flags and inter-job gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROW_LEN; i++) row_r[i] <= {WIDTH{1'b0}};
      for (int i = 0; i < K; i++)       filt_r[i] <= {WIDTH{1'b0}};
      row_loaded_r  <= 1'b0;
      filt_loaded_r <= 1'b0;
      gap_r         <= {GAP_W{1'b0}};
    end else if (state_r == DONE) begin
      row_loaded_r  <= 1'b0;
      filt_loaded_r <= 1'b0;
      gap_r         <= GAP_W'(GAP);
    end else begin
      if (wr_ok_s && !wr_sel && (int'(wr_addr) < ROW_LEN)) begin
        row_r[wr_addr] <= wr_data;
        if (int'(wr_addr) == ROW_LEN-1) row_loaded_r <= 1'b1;
      end
      if (wr_ok_s && wr_sel && (int'(wr_addr) < K)) begin
        filt_r[wr_addr[FILT_AW-1:0]] <= wr_data;
        if (int'(wr_addr) == K-1) filt_loaded_r <= 1'b1;
      end
      if ((state_r == IDLE) && (gap_r != {GAP_W{1'b0}})) begin
        gap_r <= gap_r - GAP_W'(1);
      end
    end
  end

  conv8_psum_collector #(.WIDTH(WIDTH)) u_collector (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en_s),
    .psum     (pe.i_psum),
    .cap_last (cap_last_s),
    .res      (o_res)
  );

  assign pe.o_en = o_en_r;
  assign pe.o_f  = o_f_r;
  assign pe.o_r  = o_r_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_conv8_row_feeder.sv
// Scoreboard bench for conv8_row_feeder; expected ReLU results follow CONV8_FEEDER_RELU_EN.
module tb_conv8_row_feeder;
  import conv8_row_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel, start;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done;
  logic [63:0] o_res;

  conv8_row_feeder_if #(.WIDTH(8)) pe_if ();

  conv8_row_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .pe(pe_if.master),
    .o_res(o_res), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] r; logic [7:0] f; } beat_t;
  beat_t       beat_q[$];
  logic [63:0] res_q[$];
  int          done_cyc_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tb_row [8];
  logic [7:0]  tb_filt [3];
  beat_t       mb;
  logic [63:0] mres;
  int          mcyc;

`ifdef CONV8_FEEDER_RELU_EN
  localparam logic [63:0] RES_SIGNED = 64'h7FFF_0000_0010_0000;
`else
  localparam logic [63:0] RES_SIGNED = 64'h7FFF_8000_0010_FFF0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every beat and every done pulse against the scoreboard
  always @(negedge clk) begin
    if (pe_if.o_en === 1'b1) begin
      if (beat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: actual o_en=1 o_r=%0h expected no beat (cycle %0d)", pe_if.o_r, cyc);
      end else begin
        mb = beat_q.pop_front();
        check("beat_cycle", 64'(cyc), 64'(mb.cyc));
        check("beat_o_r", 64'(pe_if.o_r), 64'(mb.r));
        check("beat_o_f", 64'(pe_if.o_f), 64'(mb.f));
        check("beat_busy", 64'(busy), 64'd1);
      end
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: actual done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mres = res_q.pop_front();
        mcyc = done_cyc_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mcyc));
        check("o_res", o_res, mres);
        check("done_busy", 64'(busy), 64'd1);
      end
    end
  end

  task automatic wr(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input logic sel, input int addr, input logic [7:0] data);
    if (sel) tb_filt[addr] = data;
    else     tb_row[addr]  = data;
    wr(sel, 3'(addr), data);
  endtask

  task automatic push_beats(input int c0, input int n);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.cyc = c0 + 1 + b;
      e.r   = tb_row[b];
      e.f   = (b < 3) ? tb_filt[b] : 8'h00;
      beat_q.push_back(e);
    end
  endtask

  // Full job from a negedge: start, psums on cycles 9..12, done expected on cycle 13
  task automatic run_job(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                         input logic [15:0] p3, input logic [63:0] res_exp);
    start = 1'b1;
    push_beats(cyc, 8);
    res_q.push_back(res_exp);
    done_cyc_q.push_back(cyc + 13);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    pe_if.i_psum = p0; @(negedge clk);
    pe_if.i_psum = p1; @(negedge clk);
    pe_if.i_psum = p2; @(negedge clk);
    pe_if.i_psum = p3; @(negedge clk);
    pe_if.i_psum = 16'h0000;
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("res_hold", o_res, res_exp);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    start = 1'b0; pe_if.i_psum = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_o_en", 64'(pe_if.o_en), 64'd0);
    check("rst_o_f", 64'(pe_if.o_f), 64'd0);
    check("rst_o_r", 64'(pe_if.o_r), 64'd0);
    check("rst_o_res", o_res, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Job 1: row 1..8, taps 1,2,3
    for (int i = 0; i < 8; i++) load(1'b0, i, 8'(i + 1));
    for (int i = 0; i < 3; i++) load(1'b1, i, 8'(i + 1));
    run_job(16'h0011, 16'h0022, 16'h0033, 16'h0044, 64'h0044_0033_0022_0011);

    // Start inside the gap, flags already cleared: ignored
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("gap_start_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    check("gap_start_busy1", 64'(busy), 64'd0);

    // Only row loaded: start ignored
    for (int i = 0; i < 8; i++) load(1'b0, i, 8'(8'h10 + i));
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("row_only_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    check("row_only_busy1", 64'(busy), 64'd0);

    // Last tap written together with start: evaluated on pre-write flags
    load(1'b1, 0, 8'h07);
    load(1'b1, 1, 8'h08);
    tb_filt[2] = 8'h09;
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd2; wr_data = 8'h09; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("start_prewrite_busy", 64'(busy), 64'd0);

    // Job 2 with writes attempted during SEND
    fork
      run_job(16'h0100, 16'h0200, 16'h0300, 16'h0400, 64'h0400_0300_0200_0100);
      begin
        repeat (2) @(negedge clk);
        wr(1'b0, 3'd0, 8'hFF);
        wr(1'b1, 3'd0, 8'hEE);
      end
    join

    // Job 3: reload rows 1..7 and taps 1..2 only; row[0]=0x10 and tap0=7 must survive
    for (int i = 1; i < 8; i++) load(1'b0, i, 8'(8'h20 + i));
    load(1'b1, 1, 8'h02);
    load(1'b1, 2, 8'h03);
    wr(1'b1, 3'd4, 8'h99);
    run_job(16'hFFF0, 16'h0010, 16'h8000, 16'h7FFF, RES_SIGNED);

    // Reset during beat 4
    for (int i = 0; i < 8; i++) load(1'b0, i, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) load(1'b1, i, 8'(i + 4));
    start = 1'b1;
    push_beats(cyc, 5);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_o_en", 64'(pe_if.o_en), 64'd0);
    check("abort_o_f", 64'(pe_if.o_f), 64'd0);
    check("abort_o_r", 64'(pe_if.o_r), 64'd0);
    check("abort_o_res", o_res, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("abort_restart_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    check("abort_restart_busy1", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    check("beats_left", 64'(beat_q.size()), 64'd0);
    check("results_left", 64'(res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv8_row_feeder.md
Name: conv8_row_feeder

Overview:
- Transmit end of the 1-D stride-2 / pad-1 conv row interface: buffers one feature row (8 pixels) and one 3-tap filter row.
- Streams them into the row PE array as the en / filter / row beat sequence the array consumes.
- Captures the 4 serial partial sums the array returns and presents them as one packed result with a done pulse.
- Sits between the layer controller / SRAM reader and the row PE array.

Parameters:
- WIDTH, 8 (= conv8_width), data width of pixel and tap.
- ROW_LEN, 8, pixels per row (beats with en high).
- K, 3, filter taps.
- N_OUT, 4, psums per row (ROW_LEN/2).
- PSUM_LAT, 8, cycles from first en-high beat to first valid psum on i_psum.
- GAP, 4, minimum en-low cycles between jobs; lets the array flush its buffers and FSM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  load strobe
- wr_sel  in  1  0 = row buffer, 1 = filter buffer
- wr_addr  in  3  buffer index
- wr_data  in  WIDTH  load data
- start  in  1  start-job pulse
- busy  out  1  job in progress
- o_en  out  1  enable to PE array
- o_f  out  WIDTH  filter tap beat
- o_r  out  WIDTH  row pixel beat
- i_psum  in  2*WIDTH  serial psum from PE array
- o_res  out  N_OUT*2*WIDTH  packed results, element 0 in LSBs
- done  out  1  one-cycle pulse, o_res valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; all state updates on posedge clk.
- Reset values: busy=0, o_en=0, o_f=0, o_r=0, o_res=0, done=0; buffers cleared; row_loaded=0, filt_loaded=0; FSM in IDLE.
- Load path (accepted in IDLE only):
  - wr_sel=0: wr_addr<ROW_LEN writes row[wr_addr].
  - wr_sel=1: wr_addr<K writes filt[wr_addr].
  - Out-of-range addresses are ignored.
  - row_loaded sets after row[ROW_LEN-1] is written; filt_loaded sets after filt[K-1] is written.
  - Writes while busy=1 are ignored; buffers are not corrupted.
- FSM states and transitions:
  - IDLE: start && row_loaded && filt_loaded && gap_cnt==0 -> SEND, busy=1. Otherwise start is ignored.
  - SEND: ROW_LEN cycles, beat index b=0..ROW_LEN-1. o_en=1, o_r=row[b], o_f = filt[b] if b<K else 0. All three outputs are registered. Beat 0 appears on the cycle after the start is accepted. After the last beat -> WAIT.
  - WAIT: o_en=0, o_f=0, o_r=0. A cycle counter runs from the first beat. When it reaches PSUM_LAT -> CAPT.
  - CAPT: N_OUT cycles; cycle j registers i_psum into o_res element j. After j=N_OUT-1 -> DONE.
  - DONE: one cycle. done=1, busy stays 1. Clears row_loaded and filt_loaded, loads gap_cnt=GAP -> IDLE.
- gap_cnt decrements in IDLE down to 0. A start issued while gap_cnt>0 is ignored, not queued.
- o_res holds its value until the next DONE overwrites it.
- Latency: start accepted at cycle 0 -> done at cycle 1+PSUM_LAT+N_OUT (13 with defaults).
- start and wr_en in the same IDLE cycle: the write takes effect and start is evaluated against pre-write flags.
- rst mid-job: immediate return to IDLE with reset values. o_en drops the next edge. Loaded data is discarded.
- psum arithmetic: pass-through, no width change; no sign handling unless the optional feature is enabled.

Optional Feature:
- Macro CONV8_FEEDER_RELU_EN.
- Defined: each captured psum is treated as signed 2*WIDTH. A negative value (MSB=1) is stored as 0, otherwise stored unchanged. Adds no latency.
- Undefined: raw capture.

Decomposition:
- Shared package (definition) holds:
  - conv8_width.
  - A typedef for psum (logic [2*conv8_width-1:0]).
  - An enum type for feeder states {IDLE, SEND, WAIT, CAPT, DONE}.
  - Constants ROW_LEN=8, K=3, N_OUT=4.
- One natural sub-module: conv8_psum_collector. It holds the CAPT index counter, the optional ReLU and the packed o_res register, driven by a capture-enable from the FSM.

Test Plan:
- Load row 1..8 and taps 1,2,3, then start -> o_en high for exactly 8 cycles; o_r = 1..8; o_f = 1,2,3,0,0,0,0,0; busy=1.
- Drive i_psum = 0x0011,0x0022,0x0033,0x0044 on capture cycles 8..11 after the first beat -> done pulse at cycle 13; o_res = 0x0044_0033_0022_0011.
- Start with only the row loaded, then start again within 4 cycles after a done -> no o_en, busy stays 0.
- Writes during SEND (row[0]=0xFF), then a second job after a fresh load -> first job streams the original data; the ignored write has no effect.
- rst asserted at beat 4 of SEND -> next cycle all outputs are 0 and the FSM is in IDLE; a new start without reload is ignored.
- With CONV8_FEEDER_RELU_EN defined, capture 0xFFF0 and 0x0010 -> o_res elements 0x0000 and 0x0010; without the macro -> 0xFFF0 and 0x0010.
